control_unit: RTL and testbench

//  Multicycle control FSM for the RV64 datapath. Decodes the latched instruction word and

---
 rtl/control_unit.sv | 277 +++++++++++++++++++++++++++
 tb/tb_control_unit.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// control_unit: multicycle control FSM for the RV64 datapath (add/sub/and/or, addi, ld, sd, beq).
// Optional: define BREAK_HALT_EN so that ebreak parks the FSM in HALT until reset.
module control_unit #(
    parameter int FETCH_WAIT = 0,
    parameter int ALUOP_W    = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [31:0]        instruction,
    output logic               PCWrite,
    output logic               PCWriteCond,
    output logic               PCSource,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic               LoadAOut,
    output logic               RegWrite,
    output logic               LoadRegA,
    output logic               LoadRegB,
    output logic               MemToReg,
    output logic               DMemOp,
    output logic               LoadMDR,
    output logic               IMemRead,
    output logic               IRWrite,
    output logic               illegal,
    output logic               halted,
    output logic [3:0]         state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_WB_ALU   = 4'd3,
        S_EXEC_I   = 4'd4,
        S_MEM_ADDR = 4'd5,
        S_MEM_RD   = 4'd6,
        S_WB_MEM   = 4'd7,
        S_MEM_WR   = 4'd8,
        S_BRANCH   = 4'd9,
        S_HALT     = 4'd10
    } state_t;

    typedef struct packed {
        logic               pc_write;
        logic               pc_write_cond;
        logic               pc_source;
        logic               alu_src_a;
        logic [1:0]         alu_src_b;
        logic [ALUOP_W-1:0] alu_op;
        logic               load_aout;
        logic               reg_write;
        logic               load_reg_a;
        logic               load_reg_b;
        logic               mem_to_reg;
        logic               dmem_op;
        logic               load_mdr;
        logic               imem_read;
        logic               ir_write;
        logic               halted;
    } ctl_t;

    localparam logic [ALUOP_W-1:0] OP_ADD = ALUOP_W'(0);
    localparam logic [ALUOP_W-1:0] OP_SUB = ALUOP_W'(1);
    localparam logic [ALUOP_W-1:0] OP_AND = ALUOP_W'(2);
    localparam logic [ALUOP_W-1:0] OP_OR  = ALUOP_W'(3);

    localparam logic [6:0] OPC_R  = 7'b0110011;
    localparam logic [6:0] OPC_I  = 7'b0010011;
    localparam logic [6:0] OPC_LD = 7'b0000011;
    localparam logic [6:0] OPC_SD = 7'b0100011;
    localparam logic [6:0] OPC_BR = 7'b1100011;

    state_t             r_state;
    logic [3:0]         r_wait;
    ctl_t               r_ctl;

    state_t             w_next_state;
    logic [3:0]         w_next_wait;
    state_t             w_ctl_state;
    logic [3:0]         w_ctl_wait;
    ctl_t               w_ctl;

    logic [6:0]         w_opcode;
    logic [2:0]         w_funct3;
    logic [6:0]         w_funct7;
    logic               w_is_r;
    logic               w_is_i;
    logic               w_is_ld;
    logic               w_is_sd;
    logic               w_is_beq;
    logic               w_is_brk;
    logic               w_legal;
    logic [ALUOP_W-1:0] w_r_op;
    logic               w_run;
    logic               w_unused;

    assign w_opcode = instruction[6:0];
    assign w_funct3 = instruction[14:12];
    assign w_funct7 = instruction[31:25];

    assign w_is_r = (w_opcode == OPC_R) &&
                    (((w_funct7 == 7'h00) &&
                      ((w_funct3 == 3'b000) ||
                       (w_funct3 == 3'b111) ||
                       (w_funct3 == 3'b110))) ||
                     ((w_funct7 == 7'h20) && (w_funct3 == 3'b000)));
    assign w_is_i   = (w_opcode == OPC_I)  && (w_funct3 == 3'b000);
    assign w_is_ld  = (w_opcode == OPC_LD) && (w_funct3 == 3'b011);
    assign w_is_sd  = (w_opcode == OPC_SD) && (w_funct3 == 3'b011);
    assign w_is_beq = (w_opcode == OPC_BR) && (w_funct3 == 3'b000);

`ifdef BREAK_HALT_EN
    assign w_is_brk = (instruction == 32'h0010_0073);
`else
    assign w_is_brk = 1'b0;
`endif

    assign w_legal = w_is_r | w_is_i | w_is_ld | w_is_sd | w_is_beq | w_is_brk;

    // R-type ALU function from {funct7[5], funct3}
    always_comb begin
        w_r_op = OP_ADD;
        unique case ({w_funct7[5], w_funct3})
            4'b1000: w_r_op = OP_SUB;
            4'b0111: w_r_op = OP_AND;
            4'b0110: w_r_op = OP_OR;
            default: w_r_op = OP_ADD;
        endcase
    end

    // Next state and fetch stall counter
    always_comb begin
        w_next_state = r_state;
        w_next_wait  = 4'd0;
        unique case (r_state)
            S_FETCH: begin
                if (r_wait == 4'(FETCH_WAIT)) begin
                    w_next_state = S_DECODE;
                end else begin
                    w_next_wait = r_wait + 4'd1;
                end
            end
            S_DECODE: begin
                unique case (1'b1)
                    w_is_r:            w_next_state = S_EXEC_R;
                    w_is_i:            w_next_state = S_EXEC_I;
                    w_is_ld, w_is_sd:  w_next_state = S_MEM_ADDR;
                    w_is_beq:          w_next_state = S_BRANCH;
                    w_is_brk:          w_next_state = S_HALT;
                    default:           w_next_state = S_FETCH;
                endcase
            end
            S_EXEC_R:   w_next_state = S_WB_ALU;
            S_EXEC_I:   w_next_state = S_WB_ALU;
            S_WB_ALU:   w_next_state = S_FETCH;
            S_MEM_ADDR: w_next_state = w_is_sd ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   w_next_state = S_WB_MEM;
            S_WB_MEM:   w_next_state = S_FETCH;
            S_MEM_WR:   w_next_state = S_FETCH;
            S_BRANCH:   w_next_state = S_FETCH;
            S_HALT:     w_next_state = S_HALT;
            default:    w_next_state = S_FETCH;
        endcase
    end

    // Reset lands in the first FETCH cycle, so its controls are preloaded too
    assign w_ctl_state = reset ? S_FETCH : w_next_state;
    assign w_ctl_wait  = reset ? 4'd0 : w_next_wait;

    // Control word for the state being entered
    always_comb begin
        w_ctl = '0;
        unique case (w_ctl_state)
            S_FETCH: begin
                w_ctl.imem_read = 1'b1;
                if (w_ctl_wait == 4'(FETCH_WAIT)) begin
                    w_ctl.ir_write  = 1'b1;
                    w_ctl.pc_write  = 1'b1;
                    w_ctl.alu_src_b = 2'b01;
                    w_ctl.alu_op    = OP_ADD;
                end
            end
            S_DECODE: begin
                w_ctl.load_reg_a = 1'b1;
                w_ctl.load_reg_b = 1'b1;
                w_ctl.alu_src_b  = 2'b11;
                w_ctl.alu_op     = OP_ADD;
                w_ctl.load_aout  = 1'b1;
            end
            S_EXEC_R: begin
                w_ctl.alu_src_a = 1'b1;
                w_ctl.alu_op    = w_r_op;
                w_ctl.load_aout = 1'b1;
            end
            S_EXEC_I, S_MEM_ADDR: begin
                w_ctl.alu_src_a = 1'b1;
                w_ctl.alu_src_b = 2'b10;
                w_ctl.load_aout = 1'b1;
            end
            S_WB_ALU: begin
                w_ctl.reg_write = 1'b1;
                w_ctl.alu_src_a = 1'b1;
                if (w_opcode == OPC_R) begin
                    w_ctl.alu_op = w_r_op;
                end else begin
                    w_ctl.alu_src_b = 2'b10;
                end
            end
            S_MEM_RD: begin
                w_ctl.alu_src_a = 1'b1;
                w_ctl.alu_src_b = 2'b10;
                w_ctl.load_mdr  = 1'b1;
            end
            S_WB_MEM: begin
                w_ctl.reg_write  = 1'b1;
                w_ctl.mem_to_reg = 1'b1;
            end
            S_MEM_WR: begin
                w_ctl.alu_src_a = 1'b1;
                w_ctl.alu_src_b = 2'b10;
                w_ctl.dmem_op   = 1'b1;
            end
            S_BRANCH: begin
                w_ctl.alu_src_a     = 1'b1;
                w_ctl.alu_op        = OP_SUB;
                w_ctl.pc_write_cond = 1'b1;
                w_ctl.pc_source     = 1'b1;
            end
            S_HALT: w_ctl.halted = 1'b1;
            default: w_ctl = '0;
        endcase
    end

    // State, stall counter and registered control word
    always_ff @(posedge clk) begin
        r_ctl <= w_ctl;
        if (reset) begin
            r_state <= S_FETCH;
            r_wait  <= 4'd0;
        end else begin
            r_state <= w_next_state;
            r_wait  <= w_next_wait;
        end
    end

    // Everything is quiet while reset is held, even mid-instruction
    assign w_run = ~reset;

    assign PCWrite     = r_ctl.pc_write & w_run;
    assign PCWriteCond = r_ctl.pc_write_cond & w_run;
    assign PCSource    = r_ctl.pc_source & w_run;
    assign ALUSrcA     = r_ctl.alu_src_a & w_run;
    assign ALUSrcB     = r_ctl.alu_src_b & {2{w_run}};
    assign ALUOp       = r_ctl.alu_op & {ALUOP_W{w_run}};
    assign LoadAOut    = r_ctl.load_aout & w_run;
    assign RegWrite    = r_ctl.reg_write & w_run;
    assign LoadRegA    = r_ctl.load_reg_a & w_run;
    assign LoadRegB    = r_ctl.load_reg_b & w_run;
    assign MemToReg    = r_ctl.mem_to_reg & w_run;
    assign DMemOp      = r_ctl.dmem_op & w_run;
    assign LoadMDR     = r_ctl.load_mdr & w_run;
    assign IMemRead    = r_ctl.imem_read & w_run;
    assign IRWrite     = r_ctl.ir_write & w_run;
    assign illegal     = (r_state == S_DECODE) & ~w_legal & w_run;
    assign state       = w_run ? r_state : 4'd0;

`ifdef BREAK_HALT_EN
    assign halted = r_ctl.halted & w_run;
`else
    assign halted = 1'b0;
`endif

    assign w_unused = &{1'b0, instruction[24:15], instruction[11:7],
                        r_ctl.halted};

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed bench for control_unit, per-cycle compare
// against a transaction-level model of each instruction's control sequence.
module tb_control_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] instruction = 32'h0;

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic       hlt, ill, irw, imr, lmdr, dmem, m2r, lrb, lra, regw, laout;
    logic [3:0] op;
    logic [1:0] sb;
    logic       sa, psrc, pwc, pw;
  } ob_t;

  logic pw0, pwc0, ps0, sa0, lao0, rw0, lra0, lrb0, m2r0;
  logic dm0, lmdr0, imr0, irw0, ill0, h0;
  logic [1:0] sb0;
  logic [3:0] op0, st0;
  logic pw3, pwc3, ps3, sa3, lao3, rw3, lra3, lrb3, m2r3;
  logic dm3, lmdr3, imr3, irw3, ill3, h3;
  logic [1:0] sb3;
  logic [3:0] op3, st3;

  control_unit #(.FETCH_WAIT(0), .ALUOP_W(4)) dut0 (
    .clk(clk), .reset(reset), .instruction(instruction),
    .PCWrite(pw0), .PCWriteCond(pwc0), .PCSource(ps0),
    .ALUSrcA(sa0), .ALUSrcB(sb0), .ALUOp(op0),
    .LoadAOut(lao0), .RegWrite(rw0), .LoadRegA(lra0),
    .LoadRegB(lrb0), .MemToReg(m2r0), .DMemOp(dm0),
    .LoadMDR(lmdr0), .IMemRead(imr0), .IRWrite(irw0),
    .illegal(ill0), .halted(h0), .state(st0)
  );

  control_unit #(.FETCH_WAIT(3), .ALUOP_W(4)) dut3 (
    .clk(clk), .reset(reset), .instruction(instruction),
    .PCWrite(pw3), .PCWriteCond(pwc3), .PCSource(ps3),
    .ALUSrcA(sa3), .ALUSrcB(sb3), .ALUOp(op3),
    .LoadAOut(lao3), .RegWrite(rw3), .LoadRegA(lra3),
    .LoadRegB(lrb3), .MemToReg(m2r3), .DMemOp(dm3),
    .LoadMDR(lmdr3), .IMemRead(imr3), .IRWrite(irw3),
    .illegal(ill3), .halted(h3), .state(st3)
  );

  ob_t g0, g3;
  assign g0 = {st0, h0, ill0, irw0, imr0, lmdr0, dm0, m2r0, lrb0,
               lra0, rw0, lao0, op0, sb0, sa0, ps0, pwc0, pw0};
  assign g3 = {st3, h3, ill3, irw3, imr3, lmdr3, dm3, m2r3, lrb3,
               lra3, rw3, lao3, op3, sb3, sa3, ps3, pwc3, pw3};

  int    checks = 0;
  int    fails = 0;
  bit    exp_valid = 1'b0;
  bit    sel = 1'b0;
  ob_t   cur;
  string tag = "";
  ob_t   hist[$];
  ob_t   q[$];
  ob_t   h[1:8];

  always @(negedge clk) begin
    ob_t g;
    if (exp_valid) begin
      g = sel ? g3 : g0;
      hist.push_back(g);
      checks++;
      if (g !== cur) begin
        fails++;
        $display("FAIL %s: got %h (state %0d) want %h (state %0d)",
                 tag, g, g.st, cur, cur.st);
      end
    end
  end

  function automatic void build(input logic [31:0] in, input int fw);
    ob_t s;
    int k;
    logic [3:0] rop;
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    opc = in[6:0];
    f3  = in[14:12];
    f7  = in[31:25];
    k = 0;
    if (opc == 7'h33 && ((f7 == 7'h00 && (f3 == 3'd0 || f3 == 3'd6 ||
        f3 == 3'd7)) || (f7 == 7'h20 && f3 == 3'd0))) k = 1;
    else if (opc == 7'h13 && f3 == 3'd0) k = 2;
    else if (opc == 7'h03 && f3 == 3'd3) k = 3;
    else if (opc == 7'h23 && f3 == 3'd3) k = 4;
    else if (opc == 7'h63 && f3 == 3'd0) k = 5;
`ifdef BREAK_HALT_EN
    else if (in == 32'h00100073) k = 6;
`endif
    if (f7 == 7'h20) rop = 4'd1;
    else if (f3 == 3'd7) rop = 4'd2;
    else if (f3 == 3'd6) rop = 4'd3;
    else rop = 4'd0;
    q.delete();
    for (int i = 0; i <= fw; i++) begin
      s = '0; s.imr = 1'b1;
      if (i == fw) begin s.irw = 1'b1; s.pw = 1'b1; s.sb = 2'b01; end
      q.push_back(s);
    end
    s = '0; s.st = 4'd1; s.lra = 1'b1; s.lrb = 1'b1;
    s.sb = 2'b11; s.laout = 1'b1; s.ill = (k == 0);
    q.push_back(s);
    case (k)
      1: begin
        s = '0; s.st = 4'd2; s.sa = 1'b1; s.op = rop; s.laout = 1'b1;
        q.push_back(s);
        s = '0; s.st = 4'd3; s.sa = 1'b1; s.op = rop; s.regw = 1'b1;
        q.push_back(s);
      end
      2: begin
        s = '0; s.st = 4'd4; s.sa = 1'b1; s.sb = 2'b10; s.laout = 1'b1;
        q.push_back(s);
        s = '0; s.st = 4'd3; s.sa = 1'b1; s.sb = 2'b10; s.regw = 1'b1;
        q.push_back(s);
      end
      3, 4: begin
        s = '0; s.st = 4'd5; s.sa = 1'b1; s.sb = 2'b10; s.laout = 1'b1;
        q.push_back(s);
        if (k == 3) begin
          s = '0; s.st = 4'd6; s.sa = 1'b1; s.sb = 2'b10; s.lmdr = 1'b1;
          q.push_back(s);
          s = '0; s.st = 4'd7; s.regw = 1'b1; s.m2r = 1'b1;
          q.push_back(s);
        end else begin
          s = '0; s.st = 4'd8; s.sa = 1'b1; s.sb = 2'b10; s.dmem = 1'b1;
          q.push_back(s);
        end
      end
      5: begin
        s = '0; s.st = 4'd9; s.sa = 1'b1; s.op = 4'd1;
        s.pwc = 1'b1; s.psrc = 1'b1;
        q.push_back(s);
      end
      6: begin
        for (int i = 0; i < 4; i++) begin
          s = '0; s.st = 4'd10; s.hlt = 1'b1; q.push_back(s);
        end
      end
      default: ;
    endcase
  endfunction

  task automatic tick();
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    tag = "reset";
    cur = '0;
    exp_valid = 1'b1;
    repeat (n) tick();
    reset = 1'b0;
  endtask

  task automatic run(input logic [31:0] in, input int fw,
                     input string name, input int stop_st = -1);
    build(in, fw);
    for (int i = 0; i < q.size(); i++) begin
      cur = q[i];
      tag = $sformatf("%s[%0d]", name, i);
      if (stop_st >= 0 && int'(q[i].st) == stop_st) begin
        @(negedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        return;
      end
      tick();
      if (i == fw) instruction = in;
    end
  endtask

  task automatic snap();
    for (int k = 1; k <= 8; k++)
      h[k] = (hist.size() >= k) ? hist[hist.size() - k] : '0;
  endtask

  task automatic lit(input string name, input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  initial begin
    do_reset(3);

    run(32'h002081B3, 0, "add");
    snap();
    lit("rst_fetch", {h[4].st, h[4].imr, h[4].irw}, {4'd0, 1'b1, 1'b1});
    lit("add_states", {h[4].st, h[3].st, h[2].st, h[1].st}, 16'h0123);
    lit("add_aluop", h[2].op, 4'h0);
    lit("add_regw", h[1].regw, 1'b1);

    run(32'h402081B3, 0, "sub");
    snap();
    lit("sub_aluop", h[2].op, 4'h1);

    run(32'h0020F1B3, 0, "and");
    snap();
    lit("and_aluop", h[2].op, 4'h2);

    run(32'h0020E1B3, 0, "or");
    snap();
    lit("or_wb_aluop", {h[1].st, h[1].op}, {4'd3, 4'h3});

    run(32'h00A08093, 0, "addi");
    snap();
    lit("addi_srcb", {h[2].st, h[2].sb}, {4'd4, 2'b10});

    run(32'h0080B283, 0, "ld");
    snap();
    lit("ld_states", {h[5].st, h[4].st, h[3].st, h[2].st, h[1].st},
        20'h01567);
    lit("ld_m2r", h[1].m2r, 1'b1);

    run(32'h0050B423, 0, "sd");
    snap();
    lit("sd_dmem", {h[1].st, h[1].dmem, h[1].regw}, {4'd8, 1'b1, 1'b0});

    run(32'h00208463, 0, "beq");
    snap();
    lit("beq_states", {h[3].st, h[2].st, h[1].st}, 12'h019);
    lit("beq_ctl", {h[1].pwc, h[1].psrc, h[1].op}, {1'b1, 1'b1, 4'h1});
    lit("beq_dec_pwc", h[2].pwc, 1'b0);

    run(32'h402071B3, 0, "bad_funct");
    snap();
    lit("bad_funct_ill", {h[1].st, h[1].ill}, {4'd1, 1'b1});

    run(32'h0000707F, 0, "bad_opc");
    snap();
    lit("bad_opc_ill", {h[1].st, h[1].ill}, {4'd1, 1'b1});

    run(32'h00100073, 0, "ebreak");
    snap();
`ifdef BREAK_HALT_EN
    lit("ebreak_halt", {h[1].st, h[1].hlt}, {4'd10, 1'b1});
    do_reset(2);
`else
    lit("ebreak_ill", {h[1].st, h[1].ill, h[1].hlt}, {4'd1, 1'b1, 1'b0});
`endif

    run(32'h0050B423, 0, "sd_rst", 8);
    run(32'h002081B3, 0, "add_after_rst");
    snap();
    lit("rst_abort", {h[4].st, h[4].dmem, h[4].irw}, {4'd0, 1'b0, 1'b1});

    sel = 1'b1;
    do_reset(2);
    run(32'h002081B3, 3, "fw3_add");
    snap();
    lit("fw3_irw", {h[7].irw, h[6].irw, h[5].irw, h[4].irw}, 4'b0001);
    lit("fw3_pcw", {h[7].pw, h[6].pw, h[5].pw, h[4].pw}, 4'b0001);
    run(32'h0080B283, 3, "fw3_ld");
    snap();
    lit("fw3_ld_tail", {h[3].st, h[2].st, h[1].st}, 12'h567);

    exp_valid = 1'b0;
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
